// File: rtl/uart_alu_interface.sv
// Byte-serial bridge between a UART receiver/transmitter pair and an ALU.
// Collects operand A, operand B and an opcode, runs the ALU and returns the result LSB byte first.
module uart_alu_interface #(
  parameter int unsigned NB_DATA = 16,
  parameter int unsigned NB_OP   = 6,
  parameter int unsigned TIMEOUT = 65535
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [7:0]         rx_data_i,
  input  logic               rx_done_i,
  input  logic               rx_frame_err_i,
  output logic [7:0]         tx_data_o,
  output logic               tx_start_o,
  input  logic               tx_done_i,
  output logic [NB_DATA-1:0] alu_a_o,
  output logic [NB_DATA-1:0] alu_b_o,
  output logic [NB_OP-1:0]   alu_op_o,
  input  logic [NB_DATA-1:0] alu_result_i,
  output logic               busy_o,
  output logic               err_abort_o,
  output logic               overrun_o
);

  localparam int unsigned N_BYTES = NB_DATA / 8;
  localparam int unsigned IW      = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
  localparam logic [IW-1:0] IDX_LAST = IW'(N_BYTES - 1);
  localparam logic [IW-1:0] IDX_ZERO = {IW{1'b0}};
  localparam logic [IW-1:0] IDX_ONE  = IW'(1);

  typedef enum logic [2:0] {
    S_A    = 3'd0,
    S_B    = 3'd1,
    S_OP   = 3'd2,
    S_EXEC = 3'd3,
    S_CAP  = 3'd4,
    S_TX   = 3'd5,
    S_TXW  = 3'd6
  } state_t;

  state_t             state_q, state_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic [31:0]        timer_q, timer_d;
  logic [NB_DATA-1:0] stage_a_q, stage_a_d;
  logic [NB_DATA-1:0] stage_b_q, stage_b_d;
  logic [NB_OP-1:0]   stage_op_q, stage_op_d;
  logic [NB_DATA-1:0] result_q, result_d;
  logic [NB_DATA-1:0] alu_a_q, alu_a_d;
  logic [NB_DATA-1:0] alu_b_q, alu_b_d;
  logic [NB_OP-1:0]   alu_op_q, alu_op_d;
  logic [7:0]         tx_data_q, tx_data_d;
  logic               tx_start_q, tx_start_d;
  logic               busy_q, busy_d;
  logic               err_abort_q, err_abort_d;
  logic               overrun_q, overrun_d;

  logic [IW+2:0]      base_s;
  logic               rx_good_s;
  logic               collecting_s;
  logic               partial_s;
  logic               timeout_hit_s;
  logic               abort_s;
  logic               last_s;

  assign base_s       = {idx_q, 3'b000};
  assign last_s       = (idx_q == IDX_LAST);
  assign rx_good_s    = rx_done_i && !rx_frame_err_i;
  assign collecting_s = (state_q == S_A) || (state_q == S_B) || (state_q == S_OP);
  assign partial_s    = ((state_q == S_A) && (idx_q != IDX_ZERO)) ||
                        (state_q == S_B) || (state_q == S_OP);
  // An incoming byte on the expiry cycle takes priority over the timeout.
  assign timeout_hit_s = (TIMEOUT != 32'd0) && partial_s && !rx_done_i &&
                         (timer_q == TIMEOUT);
  assign abort_s      = collecting_s && ((rx_done_i && rx_frame_err_i) || timeout_hit_s);

  // Register bank for state, staging, ALU drive and UART outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_A;
      idx_q       <= IDX_ZERO;
      timer_q     <= 32'd0;
      stage_a_q   <= {NB_DATA{1'b0}};
      stage_b_q   <= {NB_DATA{1'b0}};
      stage_op_q  <= {NB_OP{1'b0}};
      result_q    <= {NB_DATA{1'b0}};
      alu_a_q     <= {NB_DATA{1'b0}};
      alu_b_q     <= {NB_DATA{1'b0}};
      alu_op_q    <= {NB_OP{1'b0}};
      tx_data_q   <= 8'd0;
      tx_start_q  <= 1'b0;
      busy_q      <= 1'b0;
      err_abort_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      timer_q     <= timer_d;
      stage_a_q   <= stage_a_d;
      stage_b_q   <= stage_b_d;
      stage_op_q  <= stage_op_d;
      result_q    <= result_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_op_q    <= alu_op_d;
      tx_data_q   <= tx_data_d;
      tx_start_q  <= tx_start_d;
      busy_q      <= busy_d;
      err_abort_q <= err_abort_d;
      overrun_q   <= overrun_d;
    end
  end

  // Next-state and datapath logic for the collect / execute / transmit sequence.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    stage_a_d   = stage_a_q;
    stage_b_d   = stage_b_q;
    stage_op_d  = stage_op_q;
    result_d    = result_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_op_d    = alu_op_q;
    tx_data_d   = tx_data_q;
    tx_start_d  = 1'b0;
    err_abort_d = 1'b0;
    overrun_d   = overrun_q;

    if (rx_done_i || !partial_s) begin
      timer_d = 32'd0;
    end else begin
      timer_d = timer_q + 32'd1;
    end

    if (rx_done_i && !collecting_s) begin
      overrun_d = 1'b1;
    end else begin
      overrun_d = overrun_q;
    end

    if (abort_s) begin
      state_d     = S_A;
      idx_d       = IDX_ZERO;
      err_abort_d = 1'b1;
    end else begin
      case (state_q)
        S_A: begin
          if (rx_good_s) begin
            stage_a_d[base_s +: 8] = rx_data_i;
            if (last_s) begin
              idx_d   = IDX_ZERO;
              state_d = S_B;
            end else begin
              idx_d = idx_q + IDX_ONE;
            end
          end else begin
            idx_d = idx_q;
          end
        end
        S_B: begin
          if (rx_good_s) begin
            stage_b_d[base_s +: 8] = rx_data_i;
            if (last_s) begin
              idx_d   = IDX_ZERO;
              state_d = S_OP;
            end else begin
              idx_d = idx_q + IDX_ONE;
            end
          end else begin
            idx_d = idx_q;
          end
        end
        S_OP: begin
          if (rx_good_s) begin
            stage_op_d = rx_data_i[NB_OP-1:0];
            state_d    = S_EXEC;
          end else begin
            state_d = S_OP;
          end
        end
        S_EXEC: begin
          alu_a_d  = stage_a_q;
          alu_b_d  = stage_b_q;
          alu_op_d = stage_op_q;
          state_d  = S_CAP;
        end
        S_CAP: begin
          result_d = alu_result_i;
          idx_d    = IDX_ZERO;
          state_d  = S_TX;
        end
        S_TX: begin
          tx_data_d  = result_q[base_s +: 8];
          tx_start_d = 1'b1;
          state_d    = S_TXW;
        end
        S_TXW: begin
          if (tx_done_i) begin
            if (last_s) begin
              idx_d   = IDX_ZERO;
              state_d = S_A;
            end else begin
              idx_d   = idx_q + IDX_ONE;
              state_d = S_TX;
            end
          end else begin
            state_d = S_TXW;
          end
        end
        default: begin
          state_d = S_A;
          idx_d   = IDX_ZERO;
        end
      endcase
    end

    busy_d = (state_d == S_EXEC) || (state_d == S_CAP) ||
             (state_d == S_TX)   || (state_d == S_TXW);
  end

  assign tx_data_o   = tx_data_q;
  assign tx_start_o  = tx_start_q;
  assign alu_a_o     = alu_a_q;
  assign alu_b_o     = alu_b_q;
  assign alu_op_o    = alu_op_q;
  assign busy_o      = busy_q;
  assign err_abort_o = err_abort_q;
  assign overrun_o   = overrun_q;

endmodule

// File: tb/tb_uart_alu_interface.sv
// Self-checking bench for uart_alu_interface: table vectors, corner sequences and random traffic
// against a byte-level reference model with an ADD/SUB ALU and a 10-clock transmitter.
module tb_uart_alu_interface;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  rx_data;
  logic        rx_done;
  logic        rx_frame_err;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_done;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [5:0]  alu_op;
  logic [15:0] alu_result;
  logic        busy;
  logic        err_abort;
  logic        overrun;

  int n_cmp = 0;
  int n_bad = 0;
  int err_cnt = 0;
  int dbl_start = 0;
  int tx_cnt = 0;
  logic prev_start = 1'b0;
  logic [7:0] txq[$];

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [7:0]  op;
    logic [15:0] res;
  } vec_t;
  vec_t tbl[5];

  uart_alu_interface #(.NB_DATA(16), .NB_OP(6), .TIMEOUT(100)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .rx_data_i(rx_data), .rx_done_i(rx_done), .rx_frame_err_i(rx_frame_err),
    .tx_data_o(tx_data), .tx_start_o(tx_start), .tx_done_i(tx_done),
    .alu_a_o(alu_a), .alu_b_o(alu_b), .alu_op_o(alu_op), .alu_result_i(alu_result),
    .busy_o(busy), .err_abort_o(err_abort), .overrun_o(overrun)
  );

  always #5 clk = ~clk;

  // Environment ALU.
  assign alu_result = (alu_op == 6'h20) ? alu_a + alu_b :
                      (alu_op == 6'h22) ? alu_a - alu_b : 16'h0000;

  // Transmitter model and output monitor.
  always @(negedge clk) begin
    if (!rst_n) begin
      tx_cnt     <= 0;
      tx_done    <= 1'b0;
      prev_start <= 1'b0;
    end else begin
      tx_done    <= (tx_cnt == 1);
      prev_start <= tx_start;
      if (tx_start && prev_start) dbl_start <= dbl_start + 1;
      if (err_abort) err_cnt <= err_cnt + 1;
      if (tx_start) begin
        txq.push_back(tx_data);
        tx_cnt <= 10;
      end else if (tx_cnt > 0) begin
        tx_cnt <= tx_cnt - 1;
      end
    end
  end

  function automatic logic [15:0] model_res(input logic [15:0] a, input logic [15:0] b,
                                            input logic [7:0] op);
    logic [5:0] o;
    o = op[5:0];
    if (o == 6'h20) return a + b;
    else if (o == 6'h22) return a - b;
    else return 16'h0000;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic fe);
    @(negedge clk);
    rx_data      = b;
    rx_frame_err = fe;
    rx_done      = 1'b1;
    @(negedge clk);
    rx_done      = 1'b0;
    rx_frame_err = 1'b0;
  endtask

  task automatic run_seq(input logic [15:0] a, input logic [15:0] b, input logic [7:0] op);
    send_byte(a[7:0], 1'b0);
    send_byte(a[15:8], 1'b0);
    send_byte(b[7:0], 1'b0);
    send_byte(b[15:8], 1'b0);
    send_byte(op, 1'b0);
  endtask

  task automatic wait_tx(input int n);
    int k;
    k = 0;
    while (txq.size() < n && k < 600) begin
      @(negedge clk);
      k++;
    end
    check("tx_wait", (txq.size() >= n), 1);
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (busy && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("busy_drop", busy, 0);
  endtask

  // Full sequence with result check; returns after the FSM is back in S_A.
  task automatic do_seq(input string name, input logic [15:0] a, input logic [15:0] b,
                        input logic [7:0] op, input logic [15:0] res);
    int base;
    base = txq.size();
    run_seq(a, b, op);
    wait_tx(base + 2);
    check({name, "_tx0"}, txq[base], res[7:0]);
    check({name, "_tx1"}, txq[base+1], res[15:8]);
    check({name, "_alu_a"}, alu_a, a);
    check({name, "_alu_b"}, alu_b, b);
    check({name, "_alu_op"}, alu_op, op[5:0]);
    wait_idle();
  endtask

  initial begin
    int e0;
    int n;
    int base;
    logic [15:0] ra, rb;
    logic [7:0]  rop;

    tbl[0] = '{a: 16'h1234, b: 16'h0011, op: 8'h20, res: 16'h1245};
    tbl[1] = '{a: 16'h0000, b: 16'h0001, op: 8'h22, res: 16'hFFFF};
    tbl[2] = '{a: 16'hFFFF, b: 16'h0001, op: 8'h20, res: 16'h0000};
    tbl[3] = '{a: 16'h8000, b: 16'h7FFF, op: 8'h22, res: 16'h0001};
    tbl[4] = '{a: 16'h00FF, b: 16'h0001, op: 8'hE0, res: 16'h0100};

    rst_n = 1'b0;
    rx_data = 8'h00;
    rx_done = 1'b0;
    rx_frame_err = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outs", {tx_data, tx_start, alu_a, alu_b, alu_op, busy, err_abort, overrun}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      e0 = err_cnt;
      do_seq($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].op, tbl[i].res);
      check($sformatf("vec%0d_noabort", i), err_cnt, e0);
    end

    // Latency: opcode sampled on edge E0, tx_start visible after E3 (4th negedge after drive).
    send_byte(8'h03, 1'b0); send_byte(8'h00, 1'b0);
    send_byte(8'h04, 1'b0); send_byte(8'h00, 1'b0);
    base = txq.size();
    @(negedge clk);
    rx_data = 8'h20;
    rx_done = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      rx_done = 1'b0;
      n++;
      if (n == 1) check("busy_exec", busy, 1);
    end while (!tx_start && n < 20);
    check("latency", n, 4);
    wait_tx(base + 2);
    check("lat_tx0", txq[base], 8'h07);
    check("lat_tx1", txq[base+1], 8'h00);
    wait_idle();

    // Inter-byte timeout.
    e0 = err_cnt;
    send_byte(8'h34, 1'b0);
    repeat (104) @(negedge clk);
    check("timeout_abort", err_cnt, e0 + 1);
    do_seq("after_timeout", 16'h0001, 16'h0002, 8'h20, 16'h0003);

    // Gaps just under the limit and long idle in S_A never abort.
    e0 = err_cnt;
    repeat (150) @(negedge clk);
    base = txq.size();
    send_byte(8'h10, 1'b0);
    repeat (97) @(negedge clk);
    send_byte(8'h00, 1'b0);
    send_byte(8'h20, 1'b0);
    send_byte(8'h00, 1'b0);
    repeat (97) @(negedge clk);
    send_byte(8'h20, 1'b0);
    wait_tx(base + 2);
    check("slow_tx0", txq[base], 8'h30);
    check("slow_tx1", txq[base+1], 8'h00);
    wait_idle();
    check("slow_noabort", err_cnt, e0);

    // Framing error on the second byte of B.
    e0 = err_cnt;
    send_byte(8'h01, 1'b0); send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0); send_byte(8'h00, 1'b1);
    repeat (3) @(negedge clk);
    check("frame_abort", err_cnt, e0 + 1);
    check("frame_not_busy", busy, 0);
    do_seq("after_frame", 16'h0001, 16'h0001, 8'h20, 16'h0002);

    // Overrun: byte arriving during S_TXW is dropped.
    check("overrun_clear", overrun, 0);
    base = txq.size();
    run_seq(16'h0010, 16'h0005, 8'h22);
    wait_tx(base + 1);
    send_byte(8'h55, 1'b0);
    check("overrun_set", overrun, 1);
    wait_tx(base + 2);
    check("ovr_tx0", txq[base], 8'h0B);
    check("ovr_tx1", txq[base+1], 8'h00);
    wait_idle();
    do_seq("after_overrun", 16'h0002, 16'h0003, 8'h20, 16'h0005);
    check("overrun_sticky", overrun, 1);

    // Asynchronous reset in S_TXW.
    base = txq.size();
    run_seq(16'h0007, 16'h0001, 8'h20);
    wait_tx(base + 1);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1 check("async_reset", {tx_data, tx_start, alu_a, alu_b, alu_op, busy, err_abort, overrun}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    do_seq("after_reset", 16'h0005, 16'h0003, 8'h22, 16'h0002);

    // Random traffic against the reference model.
    for (int i = 0; i < 16; i++) begin
      ra  = 16'($urandom);
      rb  = 16'($urandom);
      rop = ($urandom_range(0, 1) == 1) ? 8'h22 : 8'h20;
      rop[7:6] = 2'($urandom_range(0, 3));
      repeat ($urandom_range(0, 5)) @(negedge clk);
      e0 = err_cnt;
      do_seq($sformatf("rnd%0d", i), ra, rb, rop, model_res(ra, rb, rop));
      check($sformatf("rnd%0d_noabort", i), err_cnt, e0);
    end

    check("no_double_start", dbl_start, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
